// File: rtl/dbus_pack_seq.sv
// Data-bus upshifter sequencer: splits a 1/2/4/8-byte transfer into device-width
// beats, driving the byte-shift select and the assembly-register byte latch enables.
module dbus_pack_seq #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       sys_clk,
   input  logic       resetl,
   input  logic       req,
   input  logic [1:0] req_size,
   input  logic [2:0] req_addr,
   input  logic [1:0] dev_width,
   output logic       busy,
   output logic       mreq,
   output logic [2:0] maddr,
   input  logic       mack,
   output logic [2:0] dmuxu,
   output logic [7:0] dle,
   output logic       done,
   output logic       err
);

   localparam int unsigned  TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e        state_q;
   logic [2:0]    a_q, last_q, beat_q, addr_q;
   logic [1:0]    size_q, width_q;
   logic [TW-1:0] tcnt_q;
   logic          busy_q, mreq_q, done_q, err_q;

   logic [2:0] smask_d, wmask_d, a_d, start_d, last_d;
   logic [1:0] ratio_d;

   always_comb begin
      smask_d = (3'd1 << req_size) - 3'd1;
      wmask_d = (3'd1 << dev_width) - 3'd1;
      a_d     = req_addr & ~smask_d;
      start_d = a_d & ~wmask_d;
      ratio_d = req_size - dev_width;
      last_d  = (req_size > dev_width) ? (3'd1 << ratio_d) - 3'd1 : '0;
   end

   // Lanes covered by both the transfer window and the current beat window.
   logic [3:0] nbytes, wbytes, tx_end, beat_end, lo, hi;
   logic [7:0] lanemask;

   always_comb begin
      nbytes   = 4'd1 << size_q;
      wbytes   = 4'd1 << width_q;
      tx_end   = {1'b0, a_q} + nbytes;
      beat_end = {1'b0, addr_q} + wbytes;
      lo       = (a_q > addr_q) ? {1'b0, a_q} : {1'b0, addr_q};
      hi       = (tx_end < beat_end) ? tx_end : beat_end;
      lanemask = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         lanemask[i] = (4'(i) >= lo) && (4'(i) < hi);
      end
   end

   assign dle   = (state_q == RUN && mack) ? lanemask : '0;
   assign busy  = busy_q;
   assign mreq  = mreq_q;
   assign maddr = addr_q;
   assign dmuxu = addr_q;
   assign done  = done_q;
   assign err   = err_q;

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         state_q <= IDLE;
         a_q     <= '0;
         last_q  <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         width_q <= '0;
         tcnt_q  <= '0;
         busy_q  <= 1'b0;
         mreq_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  a_q     <= a_d;
                  size_q  <= req_size;
                  width_q <= dev_width;
                  last_q  <= last_d;
                  addr_q  <= start_d;
                  beat_q  <= '0;
                  tcnt_q  <= '0;
                  busy_q  <= 1'b1;
                  mreq_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (mack) begin
                  tcnt_q <= '0;
                  if (beat_q == last_q) begin
                     mreq_q  <= 1'b0;
                     done_q  <= 1'b1;
                     addr_q  <= '0;
                     state_q <= DONE;
                  end else begin
                     beat_q <= beat_q + 3'd1;
                     addr_q <= addr_q + wbytes[2:0];
                  end
               end else if (TIMEOUT != 0 && tcnt_q == TLAST) begin
                  mreq_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  addr_q  <= '0;
                  state_q <= DONE;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dbus_pack_seq.md
Name: dbus_pack_seq

Overview:
Sequencer for the data-bus byte-lane upshifter. It breaks a 1/2/4/8-byte transfer into sub-cycles sized to the device's bus width (8/16/32/64 bits). For each beat it drives the upshifter's byte-shift select (dmuxu) and the byte latch enables of the 64-bit assembly register. It sits between the bus requester and narrow external devices.

Parameters:
TIMEOUT, 255, cycles a beat may wait for mack before the transfer aborts; 0 disables the timeout.

Ports:
sys_clk  in  1  system clock; all state changes on the rising edge.
resetl  in  1  asynchronous active-low reset.
req  in  1  transfer request; sampled only in IDLE.
req_size  in  2  transfer size: 0=1B, 1=2B, 2=4B, 3=8B.
req_addr  in  3  byte offset within the 64-bit phrase.
dev_width  in  2  device bus width: 0=8b, 1=16b, 2=32b, 3=64b.
busy  out  1  high from request accept until the done cycle, inclusive.
mreq  out  1  sub-cycle request to the device.
maddr  out  3  byte address of the current sub-cycle.
mack  in  1  device data valid for the current sub-cycle.
dmuxu  out  3  upshifter select, in bytes, for the current beat.
dle  out  8  byte-lane latch enables, one per byte lane.
done  out  1  one-cycle completion pulse.
err  out  1  one-cycle timeout pulse; coincident with done.

Behaviour:
- Reset (resetl=0, async): state=IDLE; busy, mreq, maddr, dmuxu, dle, done, err all 0; beat and timeout counters cleared. Reset in mid-transfer abandons it with no done pulse.
- Derived values at accept, all registered and held for the whole transfer:
  - N = 1<<req_size; W = 1<<dev_width.
  - a = req_addr with its low req_size bits forced to 0 (misaligned addresses are silently aligned).
  - start = a & ~(W-1).
  - beats = max(1, N/W).
- States: IDLE, RUN, DONE.
- IDLE: if req=1 at an edge, latch the derived values and go to RUN. busy=1 and mreq=1 from the next cycle, so latency req->mreq is 1 cycle.
- RUN, beat k (k=0..beats-1):
  - maddr = dmuxu = start + k*W (mod 8). Both are stable for the whole beat.
  - mreq held high.
- dle, combinational: mack & RUN & lanemask. lanemask has bit i set for every i in [max(a,dmuxu), min(a+N, dmuxu+W)). dle is 0 in all other cycles.
- mack=1 in RUN, not the last beat: k increments and the next beat's maddr/dmuxu appear the following cycle; mreq stays high with no gap.
- mack=1 in RUN, last beat: go to DONE. mreq drops the next cycle.
- DONE: one cycle with done=1 and busy=1, then IDLE. A new req is accepted from IDLE the cycle after DONE, so the minimum transfer period is beats+2 cycles.
- Timeout (TIMEOUT>0):
  - A counter clears on accept and on each mack, and increments each RUN cycle without mack.
  - When it reaches TIMEOUT-1 with no mack, go to DONE with err=1. Any remaining beats are skipped.
  - mreq is therefore high for exactly TIMEOUT cycles of the stalled beat.
- Ignored inputs:
  - req while busy has no effect and is not queued.
  - mack in IDLE or DONE has no effect and produces no dle.
- dmuxu=0 means unshifted: byte lane 0 bypasses the shifter, and dle[0] can only assert when dmuxu=0.
- Arithmetic: maddr/dmuxu wrap modulo 8, which is unreachable for aligned inputs. The beat counter is 3 bits.

Test Plan:
- 8B, addr 0, 16-bit device, mack one cycle after each beat starts -> 4 beats. dmuxu/maddr = 0,2,4,6 and dle = 03,0C,30,C0. done high 1 cycle after the 4th mack; busy low the cycle after that.
- 4B, addr 4, 8-bit device, mack held high -> dmuxu = 4,5,6,7 on consecutive cycles; dle = 10,20,40,80; mreq high for 4 cycles; then the done pulse.
- 2B, addr 5, 64-bit device -> addr aligned to 4; one beat with dmuxu=0, maddr=0, dle=30.
- 1B, addr 3, 32-bit device -> one beat with dmuxu=0, dle=08. A second req asserted while busy is ignored, so there is exactly one done pulse.
- TIMEOUT=4, 8B on an 8-bit device, mack never asserted -> mreq high for cycles 1..4, then done=err=1 in cycle 5, then IDLE. dle stays 0 throughout.
- resetl low during beat 2 of a 16-bit 8B transfer -> all outputs 0 immediately, with no done. After release, a new 1B req completes normally.
